airi5c_lshifter_norm_seq: RTL and testbench

//   Multi-cycle left-shift normalizer for the FPU datapath; the left-shift counterpart of the static right-shift alignment stage.

---
 rtl/airi5c_lshifter_norm_seq.sv | 129 ++++++++++++
 tb/tb_airi5c_lshifter_norm_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/airi5c_lshifter_norm_seq.sv
// Multi-cycle left-shift normalizer: shifts the mantissa left in log2 stages,
// one stage per cycle, without taking the exponent below EXP_MIN.
module airi5c_lshifter_norm_seq #(
  parameter int unsigned n       = 24,
  parameter int unsigned e       = 10,
  parameter int          EXP_MIN = -126
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         kill,
  input  logic         load,
  input  logic [n-1:0] in,
  input  logic [e-1:0] exp_in,
  output logic         ready,
  output logic         valid,
  output logic [n-1:0] out,
  output logic [e-1:0] exp_out,
  output logic         zero
);

  localparam int unsigned S  = $clog2(n);
  localparam int unsigned CW = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned SW = S + 1;
  localparam int unsigned EW = e + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          ready_nxt;
  logic          valid_nxt;
  logic          accept;
  logic          last;

  logic [n-1:0]  mant;
  logic [e-1:0]  exp_r;
  logic          zero_r;
  logic [CW-1:0] cnt;

  logic [SW-1:0] shift_amt;
  logic [n-1:0]  hi_mask;
  logic [EW-1:0] exp_dec;
  logic          do_shift;
  logic [n-1:0]  mant_nxt;
  logic [e-1:0]  exp_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshake flags and the current shift stage
  always_comb begin
    state_nxt = state;
    ready_nxt = 1'b0;
    valid_nxt = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;

    shift_amt = SW'(1) << cnt;
    hi_mask   = ~({n{1'b1}} >> shift_amt);
    // exponent widened by one bit so the limit check cannot wrap
    exp_dec   = {exp_r[e-1], exp_r} - EW'(shift_amt);
    do_shift  = ((mant & hi_mask) == '0) &&
                ($signed(exp_dec) >= $signed(EW'(EXP_MIN))) &&
                !zero_r;
    mant_nxt  = do_shift ? (mant << shift_amt) : mant;
    exp_nxt   = do_shift ? exp_dec[e-1:0] : exp_r;

    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = SHIFT;
          accept    = !kill;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          last      = !kill;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (kill) state_nxt = IDLE;

    ready_nxt = (state_nxt == IDLE);
    valid_nxt = (state_nxt == DONE);
  end

  // Working registers and held result
  always_ff @(posedge clk) begin
    if (reset) begin
      ready   <= 1'b1;
      valid   <= 1'b0;
      mant    <= '0;
      exp_r   <= '0;
      zero_r  <= 1'b0;
      cnt     <= '0;
      out     <= '0;
      exp_out <= '0;
      zero    <= 1'b0;
    end else begin
      ready <= ready_nxt;
      valid <= valid_nxt;
      if (accept) begin
        mant   <= in;
        exp_r  <= exp_in;
        zero_r <= (in == '0);
        cnt    <= CW'(S - 1);
      end else if (state == SHIFT && !kill) begin
        mant  <= mant_nxt;
        exp_r <= exp_nxt;
        cnt   <= CW'(cnt - 1'b1);
      end
      if (last) begin
        out     <= mant_nxt;
        exp_out <= exp_nxt;
        zero    <= zero_r;
      end
    end
  end

endmodule

// File: tb/tb_airi5c_lshifter_norm_seq.sv
// Directed bench for the left-shift normalizer (n=8, e=8, EXP_MIN=-5).
module tb_airi5c_lshifter_norm_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       kill;
  logic       load;
  logic [7:0] in_v;
  logic [7:0] exp_in;
  logic       ready;
  logic       valid;
  logic [7:0] out_v;
  logic [7:0] exp_out;
  logic       zero;

  int checks = 0;
  int errors = 0;

  airi5c_lshifter_norm_seq #(.n(8), .e(8), .EXP_MIN(-5)) dut (
    .clk     (clk),
    .reset   (reset),
    .kill    (kill),
    .load    (load),
    .in      (in_v),
    .exp_in  (exp_in),
    .ready   (ready),
    .valid   (valid),
    .out     (out_v),
    .exp_out (exp_out),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check latency and result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] ea,
                        input logic [7:0] want_m, input logic [7:0] want_e,
                        input logic want_z, input logic inject);
    int cyc;
    check({tag, "_ready_before"}, 32'(ready), 32'd1);
    in_v   = a;
    exp_in = ea;
    load   = 1'b1;
    tick();
    load = 1'b0;
    cyc  = 1;
    while (!valid && cyc < 12) begin
      load = inject && (cyc == 2);
      if (load) begin
        in_v   = 8'hFF;
        exp_in = 8'd0;
      end
      tick();
      cyc++;
    end
    load = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_out"}, 32'(out_v), 32'(want_m));
    check({tag, "_exp"}, 32'(exp_out), 32'(want_e));
    check({tag, "_zero"}, 32'(zero), 32'(want_z));
    check({tag, "_ready_done"}, 32'(ready), 32'd0);
    tick();
    check({tag, "_valid_pulse"}, 32'(valid), 32'd0);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int vseen;
    reset  = 1'b1;
    kill   = 1'b0;
    load   = 1'b1;
    in_v   = 8'h55;
    exp_in = 8'd3;
    tick();
    tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_out", 32'(out_v), 32'd0);
    check("rst_exp", 32'(exp_out), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    reset = 1'b0;
    load  = 1'b0;
    tick();

    run_op("lim",   8'h01, 8'd0,   8'h20, 8'hFB, 1'b0, 1'b0);
    run_op("mid",   8'h13, 8'd20,  8'h98, 8'd17, 1'b0, 1'b0);
    run_op("norm",  8'h80, 8'd3,   8'h80, 8'd3,  1'b0, 1'b0);
    run_op("zero",  8'h00, 8'd7,   8'h00, 8'd7,  1'b1, 1'b0);
    run_op("atmin", 8'h01, 8'hFB,  8'h01, 8'hFB, 1'b0, 1'b0);
    run_op("below", 8'h01, 8'hF9,  8'h01, 8'hF9, 1'b0, 1'b0);

    // kill two cycles after load, with load held through the kill cycle
    in_v   = 8'h40;
    exp_in = 8'd0;
    load   = 1'b1;
    tick();
    check("kill_busy", 32'(ready), 32'd0);
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    load = 1'b0;
    check("kill_ready", 32'(ready), 32'd1);
    check("kill_valid", 32'(valid), 32'd0);
    check("kill_out", 32'(out_v), 32'h01);
    check("kill_exp", 32'(exp_out), 32'hF9);
    check("kill_zero", 32'(zero), 32'd0);
    vseen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid) vseen++;
    end
    check("kill_no_valid", 32'(vseen), 32'd0);
    check("kill_idle", 32'(ready), 32'd1);

    // a load while busy is ignored; the next op follows straight after DONE
    run_op("busy", 8'h13, 8'd20, 8'h98, 8'd17, 1'b0, 1'b1);
    run_op("b2b",  8'h01, 8'd0,  8'h20, 8'hFB, 1'b0, 1'b0);

    // reset in the middle of an operation
    in_v   = 8'h03;
    exp_in = 8'd10;
    load   = 1'b1;
    tick();
    load = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_ready", 32'(ready), 32'd1);
    check("rst2_valid", 32'(valid), 32'd0);
    check("rst2_out", 32'(out_v), 32'd0);
    check("rst2_exp", 32'(exp_out), 32'd0);
    vseen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid) vseen++;
    end
    check("rst2_no_valid", 32'(vseen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
